bomb_game_ctrl: RTL

- Top-level game sequencer that drives the 3-bit game state consumed by the center countdown timer and the puzzle modules.
- Latches the difficulty selection into the timer's `time_limit_1`/`time_limit_0` inputs at game start.
- Counts strikes from the puzzle modules and decides between success, detonation and failure.
- Sits between the board buttons/switches, the timer and the puzzle modules; the only writer of `current_state`.

---
 rtl/bomb_pkg.sv | 25 ++
 rtl/rise_edge_det.sv | 19 +
 rtl/bomb_game_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bomb_pkg.sv
// Shared game-state and difficulty encodings for the bomb board.
package bomb_pkg;

  typedef enum logic [2:0] {
    IDLE              = 3'b000,
    ATIVATING         = 3'b001,
    ATIVATED          = 3'b010,
    DETONATING        = 3'b011,
    MISSION_FAILED    = 3'b100,
    MISSION_SUCCESSED = 3'b101
  } game_state_e;

  localparam logic [1:0] DIFF_LONG   = 2'b00;
  localparam logic [1:0] DIFF_MEDIUM = 2'b01;
  localparam logic [1:0] DIFF_SHORT  = 2'b10;

  localparam logic [6:0] PHASE_LAST = 7'd99;

  function automatic logic [1:0] map_diff(
    input logic [1:0] sw
  );
    return (sw == 2'b11) ? DIFF_LONG : sw;
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector; register resets high so a level held
// through reset is not seen as an edge.
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) d_q <= 1'b1;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb game sequencer: state, strikes, difficulty latch, buzzer.
// Optional warning beeps in ATIVATED: BOMB_CTRL_WARN_BEEP_EN.
module bomb_game_ctrl #(
  parameter int MAX_STRIKES    = 3,
  parameter int ARM_CYCLES     = 2,
  parameter int DETONATE_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_10ms,
  input  logic       start_btn,
  input  logic [1:0] diff_sw,
  input  logic       strike_pulse,
  input  logic       all_defused,
  input  logic       time_out,
  input  logic       one_min_left,
  input  logic       ten_sec_left,
  output logic [2:0] current_state,
  output logic       time_limit_1,
  output logic       time_limit_0,
  output logic [2:0] strike_count,
  output logic       buzzer_en,
  output logic       game_over
);
  import bomb_pkg::*;

  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam int TW = $clog2(DETONATE_TICKS + 1);
  localparam logic [2:0]    MAX_S    = 3'(MAX_STRIKES);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);
  localparam logic [TW-1:0] DET_LAST = TW'(DETONATE_TICKS - 1);

  game_state_e   state_q, state_d;
  logic [2:0]    strike_q, strike_d;
  logic [AW-1:0] arm_q, arm_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          det_entry_q, det_entry_d;
  logic [1:0]    tl_q, tl_d;
  logic          buzz_q, buzz_d;
  logic          over_q, over_d;
  logic          start_rise;

`ifdef BOMB_CTRL_WARN_BEEP_EN
  logic [6:0]    phase_q, phase_d;
`else
  logic          unused_warn;
  assign unused_warn = ^{one_min_left, ten_sec_left};
`endif

  rise_edge_det u_start_det (
    .clk  (clk),
    .rst  (rst),
    .d    (start_btn),
    .rise (start_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      strike_q    <= '0;
      arm_q       <= '0;
      tick_q      <= '0;
      det_entry_q <= 1'b0;
      tl_q        <= DIFF_LONG;
      buzz_q      <= 1'b0;
      over_q      <= 1'b0;
`ifdef BOMB_CTRL_WARN_BEEP_EN
      phase_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      strike_q    <= strike_d;
      arm_q       <= arm_d;
      tick_q      <= tick_d;
      det_entry_q <= det_entry_d;
      tl_q        <= tl_d;
      buzz_q      <= buzz_d;
      over_q      <= over_d;
`ifdef BOMB_CTRL_WARN_BEEP_EN
      phase_q     <= phase_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start_rise) state_d = ATIVATING;
      ATIVATING:
        if (arm_q == ARM_LAST) state_d = ATIVATED;
      ATIVATED: begin
        if (time_out)
          state_d = DETONATING;
        else if (strike_pulse &&
                 strike_q == MAX_S - 3'd1)
          state_d = DETONATING;
        else if (all_defused)
          state_d = MISSION_SUCCESSED;
      end
      DETONATING:
        if (!det_entry_q && tick_10ms &&
            tick_q == DET_LAST)
          state_d = MISSION_FAILED;
      MISSION_FAILED, MISSION_SUCCESSED:
        if (start_rise) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    strike_d = strike_q;
    tick_d   = tick_q;
    tl_d     = tl_q;
    arm_d    = '0;

    if (state_q == IDLE && start_rise) begin
      tl_d     = map_diff(diff_sw);
      strike_d = '0;
    end

    if (state_q == ATIVATING) arm_d = arm_q + AW'(1);

    // success outranks a non-final strike, so it only counts
    // when we stay armed or the strike itself detonates
    if (state_q == ATIVATED && !time_out &&
        strike_pulse && strike_q < MAX_S &&
        (state_d == ATIVATED ||
         state_d == DETONATING))
      strike_d = strike_q + 3'd1;

    det_entry_d = (state_d == DETONATING) &&
                  (state_q != DETONATING);
    if (det_entry_d)
      tick_d = '0;
    else if (state_q == DETONATING &&
             !det_entry_q && tick_10ms)
      tick_d = tick_q + TW'(1);

    over_d = (state_d == MISSION_FAILED) ||
             (state_d == MISSION_SUCCESSED);
    buzz_d = (state_d == DETONATING);

`ifdef BOMB_CTRL_WARN_BEEP_EN
    phase_d = '0;
    if (state_q == ATIVATED) begin
      phase_d = phase_q;
      if (tick_10ms)
        phase_d = (phase_q == PHASE_LAST) ?
                  7'd0 : phase_q + 7'd1;
    end
    if (state_d == ATIVATED) begin
      if (ten_sec_left)
        buzz_d = (phase_d % 7'd25) < 7'd5;
      else if (one_min_left)
        buzz_d = phase_d < 7'd10;
    end
`endif
  end

  assign current_state = state_q;
  assign time_limit_1  = tl_q[1];
  assign time_limit_0  = tl_q[0];
  assign strike_count  = strike_q;
  assign buzzer_en     = buzz_q;
  assign game_over     = over_q;

endmodule
